// File: rtl/bcd_sevenseg_scan_pkg.sv
// Shared constants for the seven-segment scanner: active-low segment codes
// ({g,f,e,d,c,b,a}) and the per-slot scan state encoding.
package bcd_sevenseg_scan_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  typedef enum logic {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/bcd_sevenseg_scan_bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment decoder; any nibble
// above 9 shows "E" so a corrupted converter word is visible on the display.
module bcd_to_seg7
  import bcd_sevenseg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_E;
    case (nibble)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_E;
    endcase
  end

endmodule

// File: rtl/bcd_sevenseg_scan.sv
// Captures a BCD word on the converter's ready strobe and scans it onto a
// common-anode display with leading-zero blanking, sign digit and anode guard.
module bcd_sevenseg_scan
  import bcd_sevenseg_scan_pkg::*;
#(
  parameter int BCD_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BCD_DIGITS*4-1:0] bcd,
  input  logic                    bcd_ready,
  input  logic                    negative,
  input  logic                    blank_lz,
  output logic [BCD_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    sign_lost
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (BCD_DIGITS > 1) ? $clog2(BCD_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BCD_DIGITS - 1);

  logic [BCD_DIGITS*4-1:0] held_word;
  logic                    held_sign;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic [IDX_W-1:0]        idx, idx_next;
  logic                    cnt_wrap;
  scan_state_t             state, state_next;
  logic                    load_drive, go_guard;

  logic [3:0]              digit [BCD_DIGITS];
  logic [BCD_DIGITS-1:0]   blank, minus_pos, an_sel;
  logic [3:0]              digit_sel;
  logic [6:0]              dec_pattern, pattern_next;
  logic                    sign_lost_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held_word <= '0;
      held_sign <= 1'b0;
    end else if (bcd_ready) begin
      held_word <= bcd;
      held_sign <= negative;
    end
  end

  always_comb begin
    cnt_wrap = (cnt == CNT_LAST);
    cnt_next = cnt_wrap ? '0 : cnt + 1'b1;
    idx_next = idx;
    if (cnt_wrap) idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      idx   <= '0;
      state <= GUARD;
    end else begin
      cnt   <= cnt_next;
      idx   <= idx_next;
      state <= state_next;
    end
  end

  // Entry into DRIVE is decided from the next count so the registered anode
  // goes low on exactly the cycle the counter reads GUARD_CYCLES.
  always_comb begin
    state_next = state;
    load_drive = 1'b0;
    go_guard   = 1'b0;
    case (state)
      GUARD: begin
        if (cnt_next == CNT_GUARD) begin
          state_next = DRIVE;
          load_drive = 1'b1;
        end
      end
      DRIVE: begin
        if (cnt_wrap) begin
          if (CNT_GUARD == '0) begin
            load_drive = 1'b1;
          end else begin
            state_next = GUARD;
            go_guard   = 1'b1;
          end
        end
      end
      default: state_next = GUARD;
    endcase
  end

  always_comb begin
    for (int i = 0; i < BCD_DIGITS; i++) digit[i] = held_word[i*4 +: 4];
  end

  // Blanked digits form a contiguous run from the top; the minus sign takes
  // the lowest position of that run.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank      = '0;
    minus_pos  = '0;
    for (int i = BCD_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (digit[i] == 4'd0);
      blank[i]   = blank_lz && (i > 0) && zero_above;
    end
    for (int i = 1; i < BCD_DIGITS; i++) minus_pos[i] = blank[i] && !blank[i-1];
    sign_lost_next = held_sign && !(|blank);
  end

  assign digit_sel = digit[idx_next];

  bcd_to_seg7 u_dec (
    .nibble  (digit_sel),
    .pattern (dec_pattern)
  );

  always_comb begin
    pattern_next = dec_pattern;
    if (held_sign && minus_pos[idx_next]) pattern_next = SEG_MINUS;
    else if (blank[idx_next])             pattern_next = SEG_BLANK;
    an_sel           = '1;
    an_sel[idx_next] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an        <= '1;
      seg       <= SEG_BLANK;
      sign_lost <= 1'b0;
    end else begin
      sign_lost <= sign_lost_next;
      if (load_drive) begin
        an  <= an_sel;
        seg <= pattern_next;
      end else if (go_guard) begin
        an  <= '1;
        seg <= SEG_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Bench for bcd_sevenseg_scan: a digit-level display model checked every cycle
// plus directed scenarios with hand-computed segment patterns.
module tb_bcd_sevenseg_scan;

  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int GUARD  = 2;
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] bcd = '0;
  logic        bcd_ready = 1'b0;
  logic        negative = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        sign_lost;

  int checks = 0;
  int errors = 0;
  bit model_live = 1'b0;

  int          m_cnt, m_idx;
  logic [15:0] m_word, snap_word;
  logic        m_sign, snap_sign, snap_lz, exp_lost;

  bcd_sevenseg_scan #(
    .BCD_DIGITS   (DIGITS),
    .REFRESH_DIV  (DIV),
    .GUARD_CYCLES (GUARD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bcd       (bcd),
    .bcd_ready (bcd_ready),
    .negative  (negative),
    .blank_lz  (blank_lz),
    .an        (an),
    .seg       (seg),
    .sign_lost (sign_lost)
  );

  always #5 clk = ~clk;

  function automatic int top_digit(input logic [15:0] word);
    int top;
    top = -1;
    for (int j = 0; j < DIGITS; j++) if (word[j*4 +: 4] != 4'd0) top = j;
    return top;
  endfunction

  function automatic int minus_slot(input logic [15:0] word);
    int t;
    t = top_digit(word) + 1;
    return (t < 1) ? 1 : t;
  endfunction

  function automatic logic [6:0] model_pattern(input logic [15:0] word, input logic sign,
                                               input logic lz, input int pos);
    logic [3:0] nib;
    nib = word[pos*4 +: 4];
    if (lz && sign && pos == minus_slot(word)) return 7'b0111111;
    if (lz && pos > 0 && pos > top_digit(word)) return 7'b1111111;
    if (nib > 4'd9) return 7'b0000110;
    return SEG_TABLE[nib];
  endfunction

  function automatic logic model_lost(input logic [15:0] word, input logic sign, input logic lz);
    return sign && !(lz && minus_slot(word) < DIGITS);
  endfunction

  // Model state advances on the same edges as the display; the pattern for a
  // slot is frozen from the word held just before the anode turns on.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt <= 0; m_idx <= 0; m_word <= '0; m_sign <= 1'b0;
      snap_word <= '0; snap_sign <= 1'b0; snap_lz <= 1'b0; exp_lost <= 1'b0;
    end else begin
      exp_lost <= model_lost(m_word, m_sign, blank_lz);
      if (m_cnt == GUARD - 1) begin
        snap_word <= m_word; snap_sign <= m_sign; snap_lz <= blank_lz;
      end
      if (m_cnt == DIV - 1) begin
        m_cnt <= 0;
        m_idx <= (m_idx + 1) % DIGITS;
      end else begin
        m_cnt <= m_cnt + 1;
      end
      if (bcd_ready) begin
        m_word <= bcd; m_sign <= negative;
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    if (model_live) begin
      exp_an  = (m_cnt >= GUARD) ? ~(4'b0001 << m_idx) : 4'b1111;
      exp_seg = (m_cnt >= GUARD) ? model_pattern(snap_word, snap_sign, snap_lz, m_idx) : 7'b1111111;
      checks++;
      if (an !== exp_an || seg !== exp_seg || sign_lost !== exp_lost) begin
        errors++;
        if (errors < 30)
          $display("[TB] FAIL model @%0t: an=%b seg=%b lost=%b expected an=%b seg=%b lost=%b",
                   $time, an, seg, sign_lost, exp_an, exp_seg, exp_lost);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  // Pulses bcd_ready for one cycle; call right after a falling edge.
  task automatic applyStimulus(input logic [15:0] word, input logic neg);
    bcd = word; negative = neg; bcd_ready = 1'b1;
    @(negedge clk);
    bcd_ready = 1'b0;
  endtask

  task automatic waitDigit(input int d);
    logic [3:0] target;
    int n;
    target = ~(4'b0001 << d);
    n = 0;
    while (an == target && n < 100) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (an != target && n < 100);
    if (an != target) begin
      checks++; errors++;
      $display("[TB] FAIL wait_digit%0d: an=%b never reached %b", d, an, target);
    end
  endtask

  initial begin
    int len;
    #1 reset = 1'b0;
    #1 model_live = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_an", 16'(an), 16'b1111);
    checkOutput("reset_seg", 16'(seg), 16'b1111111);
    checkOutput("reset_lost", 16'(sign_lost), 16'd0);

    $display("[TB] scan of 1234");
    reset = 1'b1;
    applyStimulus(16'h1234, 1'b0);
    waitDigit(0);
    checkOutput("d0_is_4", 16'(seg), 16'b0011001);
    len = 0;
    while (an == 4'b1110 && len < 20) begin len++; @(negedge clk); end
    checkOutput("drive_len", 16'(len), 16'd6);
    len = 0;
    while (an == 4'b1111 && len < 20) begin len++; @(negedge clk); end
    checkOutput("guard_len", 16'(len), 16'd2);
    checkOutput("d1_an", 16'(an), 16'b1101);
    checkOutput("d1_is_3", 16'(seg), 16'b0110000);
    waitDigit(2); checkOutput("d2_is_2", 16'(seg), 16'b0100100);
    waitDigit(3); checkOutput("d3_is_1", 16'(seg), 16'b1111001);

    $display("[TB] leading zeros with sign");
    blank_lz = 1'b1;
    applyStimulus(16'h0042, 1'b1);
    repeat (40) @(negedge clk);
    waitDigit(2); checkOutput("lz_minus", 16'(seg), 16'b0111111);
    waitDigit(3); checkOutput("lz_blank", 16'(seg), 16'b1111111);
    checkOutput("lz_lost0", 16'(sign_lost), 16'd0);
    blank_lz = 1'b0;
    repeat (40) @(negedge clk);
    waitDigit(3); checkOutput("nolz_d3_0", 16'(seg), 16'b1000000);
    waitDigit(1); checkOutput("nolz_d1_4", 16'(seg), 16'b0011001);
    checkOutput("nolz_lost1", 16'(sign_lost), 16'd1);

    $display("[TB] zero and invalid nibble");
    blank_lz = 1'b1;
    applyStimulus(16'h0000, 1'b0);
    repeat (40) @(negedge clk);
    waitDigit(0); checkOutput("zero_d0", 16'(seg), 16'b1000000);
    waitDigit(1); checkOutput("zero_d1_blank", 16'(seg), 16'b1111111);
    applyStimulus(16'h0000, 1'b1);
    repeat (40) @(negedge clk);
    waitDigit(1); checkOutput("negzero_d1", 16'(seg), 16'b0111111);
    applyStimulus(16'h00A5, 1'b0);
    repeat (40) @(negedge clk);
    waitDigit(1); checkOutput("invalid_E", 16'(seg), 16'b0000110);

    $display("[TB] update timing");
    applyStimulus(16'h1234, 1'b0);
    repeat (40) @(negedge clk);
    waitDigit(1);
    repeat (2) @(negedge clk);
    applyStimulus(16'h5678, 1'b0);
    checkOutput("midslot_hold", 16'(seg), 16'b0110000);
    waitDigit(2); checkOutput("next_slot_new", 16'(seg), 16'b0000010);
    bcd = 16'h1111; bcd_ready = 1'b1;
    @(negedge clk);
    bcd = 16'h2222;
    @(negedge clk);
    bcd_ready = 1'b0;
    repeat (40) @(negedge clk);
    waitDigit(0); checkOutput("last_strobe_wins", 16'(seg), 16'b0100100);

    $display("[TB] reset mid-drive");
    waitDigit(2);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_an", 16'(an), 16'b1111);
    checkOutput("async_seg", 16'(seg), 16'b1111111);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("restart_an", 16'(an), 16'b1110);
    checkOutput("restart_seg", 16'(seg), 16'b1000000);

    $display("[TB] full negative");
    applyStimulus(16'h9999, 1'b1);
    repeat (40) @(negedge clk);
    waitDigit(3); checkOutput("full_d3_9", 16'(seg), 16'b0010000);
    checkOutput("full_lost", 16'(sign_lost), 16'd1);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
